// File: rtl/reminder_scheduler_pkg.sv
// Shared constants for the prescription reminder scheduler.
// Holds parameter defaults, FSM state encodings and the index-width helper.
package reminder_scheduler_pkg;

  localparam int unsigned DEF_NUM_MEDS     = 4;
  localparam int unsigned DEF_TICK_DIV     = 50000000;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_INTERVAL     = 8;
  localparam int unsigned DEF_RING_TIMEOUT = 30;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RING = 1'b1;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reminder_scheduler_tick_prescaler.sv
// Divides clk by TICK_DIV and emits a one-cycle tick when the count
// reaches TICK_DIV-1, at which point the count wraps to zero.
module reminder_scheduler_tick_prescaler
  import reminder_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned PW   = idx_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick_c = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/reminder_scheduler.sv
// Medicine reminder controller: per-slot interval countdowns, lowest-index
// arbitration of expired slots onto one alarm, and missed-dose tracking.
module reminder_scheduler
  import reminder_scheduler_pkg::*;
#(
  parameter int unsigned NUM_MEDS         = DEF_NUM_MEDS,
  parameter int unsigned TICK_DIV         = DEF_TICK_DIV,
  parameter int unsigned CNT_W            = DEF_CNT_W,
  parameter int unsigned DEFAULT_INTERVAL = DEF_INTERVAL,
  parameter int unsigned RING_TIMEOUT     = DEF_RING_TIMEOUT,
  localparam int unsigned IDX_W           = idx_w(NUM_MEDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                select_pulse,
  input  logic                enable_pulse,
  input  logic                ack_pulse,
  input  logic                load_pulse,
  input  logic [CNT_W-1:0]    interval_in,
  output logic [IDX_W-1:0]    sel_slot,
  output logic [NUM_MEDS-1:0] enabled_mask,
  output logic [NUM_MEDS-1:0] pending_mask,
  output logic [NUM_MEDS-1:0] missed_mask,
  output logic                alarm_active,
  output logic [IDX_W-1:0]    alarm_slot
);

  localparam int unsigned      RC_W     = idx_w(RING_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] INIT_IVL = CNT_W'(DEFAULT_INTERVAL);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [RC_W-1:0]  RT_LAST  = RC_W'(RING_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_MEDS - 1);

  logic                tick_c;
  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    alarm_slot_next;
  logic [RC_W-1:0]     ring_cnt;
  logic [RC_W-1:0]     ring_cnt_next;
  logic [IDX_W-1:0]    lowest_c;
  logic                drop_ring_c;
  logic                serve_clr_c;
  logic                miss_set_c;
  logic                ack_clr_c;
  logic [CNT_W-1:0]    load_val_c;

  logic [CNT_W-1:0]    slot_interval [NUM_MEDS];
  logic [CNT_W-1:0]    slot_count    [NUM_MEDS];
  logic [CNT_W-1:0]    interval_next [NUM_MEDS];
  logic [CNT_W-1:0]    count_next    [NUM_MEDS];
  logic [NUM_MEDS-1:0] toggle_c;
  logic [NUM_MEDS-1:0] load_c;
  logic [NUM_MEDS-1:0] expire_c;
  logic [NUM_MEDS-1:0] enabled_next;
  logic [NUM_MEDS-1:0] pending_next;
  logic [NUM_MEDS-1:0] missed_next;

  reminder_scheduler_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .tick_c (tick_c)
  );

  assign load_val_c   = (interval_in == '0) ? ONE : interval_in;
  assign alarm_active = (state == ST_RING);

  // Disabling the slot that is ringing silences it without a missed flag.
  assign drop_ring_c = enable_pulse && enabled_mask[sel_slot] && (sel_slot == alarm_slot);

  always_comb begin
    lowest_c = '0;
    for (int i = NUM_MEDS - 1; i >= 0; i--) begin
      if (pending_mask[i]) lowest_c = IDX_W'(i);
    end
  end

  // FSM next-state: ack beats timeout, a disable of the rung slot beats both.
  always_comb begin
    state_next      = state;
    alarm_slot_next = alarm_slot;
    ring_cnt_next   = ring_cnt;
    serve_clr_c     = 1'b0;
    miss_set_c      = 1'b0;
    ack_clr_c       = 1'b0;
    if (state == ST_IDLE) begin
      if (|pending_mask) begin
        state_next      = ST_RING;
        alarm_slot_next = lowest_c;
        ring_cnt_next   = '0;
      end
    end else begin
      if (drop_ring_c) begin
        state_next = ST_IDLE;
      end else if (ack_pulse) begin
        serve_clr_c = 1'b1;
        ack_clr_c   = 1'b1;
        state_next  = ST_IDLE;
      end else if (tick_c) begin
        if (ring_cnt == RT_LAST) begin
          serve_clr_c = 1'b1;
          miss_set_c  = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          ring_cnt_next = ring_cnt + RC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      alarm_slot <= '0;
      ring_cnt   <= '0;
    end else begin
      state      <= state_next;
      alarm_slot <= alarm_slot_next;
      ring_cnt   <= ring_cnt_next;
    end
  end

  // Per-slot next state; priority is enable toggle, then load, then tick.
  always_comb begin
    for (int i = 0; i < NUM_MEDS; i++) begin
      toggle_c[i]      = enable_pulse && (sel_slot == IDX_W'(i));
      load_c[i]        = load_pulse && (sel_slot == IDX_W'(i)) && !toggle_c[i];
      expire_c[i]      = 1'b0;
      enabled_next[i]  = enabled_mask[i] ^ toggle_c[i];
      interval_next[i] = load_c[i] ? load_val_c : slot_interval[i];
      count_next[i]    = slot_count[i];
      pending_next[i]  = pending_mask[i];
      missed_next[i]   = missed_mask[i];

      if (toggle_c[i]) begin
        if (!enabled_mask[i]) count_next[i] = slot_interval[i];
      end else if (load_c[i]) begin
        count_next[i] = load_val_c;
      end else if (tick_c && enabled_mask[i]) begin
        if (slot_count[i] <= ONE) begin
          count_next[i] = slot_interval[i];
          expire_c[i]   = 1'b1;
        end else begin
          count_next[i] = slot_count[i] - ONE;
        end
      end

      if (alarm_slot == IDX_W'(i)) begin
        if (serve_clr_c) pending_next[i] = 1'b0;
        if (miss_set_c)  missed_next[i]  = 1'b1;
        if (ack_clr_c)   missed_next[i]  = 1'b0;
      end
      // A fresh expiry survives the clear of the slot just served.
      if (expire_c[i]) pending_next[i] = 1'b1;
      if (toggle_c[i] && enabled_mask[i]) begin
        pending_next[i] = 1'b0;
        missed_next[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enabled_mask <= '0;
      pending_mask <= '0;
      missed_mask  <= '0;
      for (int i = 0; i < NUM_MEDS; i++) begin
        slot_interval[i] <= INIT_IVL;
        slot_count[i]    <= INIT_IVL;
      end
    end else begin
      enabled_mask <= enabled_next;
      pending_mask <= pending_next;
      missed_mask  <= missed_next;
      for (int i = 0; i < NUM_MEDS; i++) begin
        slot_interval[i] <= interval_next[i];
        slot_count[i]    <= count_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_slot <= '0;
    end else if (select_pulse) begin
      sel_slot <= (sel_slot == SEL_LAST) ? '0 : sel_slot + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_reminder_scheduler.sv
// Directed bench for reminder_scheduler with TICK_DIV=4, DEFAULT_INTERVAL=3,
// RING_TIMEOUT=2; status word = {sel, enabled, pending, missed, active, slot}.
module tb_reminder_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        select_pulse = 1'b0;
  logic        enable_pulse = 1'b0;
  logic        ack_pulse = 1'b0;
  logic        load_pulse = 1'b0;
  logic [15:0] interval_in = '0;
  logic [1:0]  sel_slot;
  logic [3:0]  enabled_mask;
  logic [3:0]  pending_mask;
  logic [3:0]  missed_mask;
  logic        alarm_active;
  logic [1:0]  alarm_slot;

  int          vectors = 0;
  int          miscompares = 0;
  logic [16:0] want;

  reminder_scheduler #(
    .NUM_MEDS         (4),
    .TICK_DIV         (4),
    .CNT_W            (16),
    .DEFAULT_INTERVAL (3),
    .RING_TIMEOUT     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .select_pulse (select_pulse),
    .enable_pulse (enable_pulse),
    .ack_pulse    (ack_pulse),
    .load_pulse   (load_pulse),
    .interval_in  (interval_in),
    .sel_slot     (sel_slot),
    .enabled_mask (enabled_mask),
    .pending_mask (pending_mask),
    .missed_mask  (missed_mask),
    .alarm_active (alarm_active),
    .alarm_slot   (alarm_slot)
  );

  always #5 clk = ~clk;

  // alarm_slot only carries meaning while ringing, so it is masked otherwise.
  function automatic logic [16:0] status();
    return {sel_slot, enabled_mask, pending_mask, missed_mask, alarm_active,
            (alarm_active ? alarm_slot : 2'd0)};
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    want = '0;
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL reset_status: got %b want %b", status(), want);
    end
    vectors++;
    if (alarm_slot !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_alarm_slot: got %0d want 0", alarm_slot);
    end
  endtask

  task automatic test_expire_ack();
    do_reset();
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    want = {2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t1_enable: got %b want %b", status(), want);
    end
    step(10);
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t1_before_expiry: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t1_pending: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t1_ring: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t1_ack: got %b want %b", status(), want);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    step(11);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_pending: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_idle_ack_ignored: got %b want %b", status(), want);
    end
    step(6);
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_still_ringing: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_missed: got %b want %b", status(), want);
    end
    step(4);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_reexpire: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_ring2: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t2_ack_clears_missed: got %b want %b", status(), want);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
    load_pulse  = 1'b1;
    interval_in = 16'd0;
    step(1);
    load_pulse   = 1'b0;
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    step(3);
    want = {2'd2, 4'b0110, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_interval1_pending: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd2, 4'b0110, 4'b0100, 4'b0000, 1'b1, 2'd2};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_ring_slot2: got %b want %b", status(), want);
    end
    step(7);
    want = {2'd2, 4'b0110, 4'b0110, 4'b0100, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_timeout_keeps_new_pending: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd2, 4'b0110, 4'b0110, 4'b0100, 1'b1, 2'd1};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_lowest_first: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd2, 4'b0110, 4'b0100, 4'b0100, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_idle_gap: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd2, 4'b0110, 4'b0100, 4'b0100, 1'b1, 2'd2};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_ring_slot2_again: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd2, 4'b0110, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t3_ack_with_tick_set: got %b want %b", status(), want);
    end
  endtask

  task automatic test_disable_ringing();
    do_reset();
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    step(10);
    want = {2'd1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t4_pending: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t4_ring: got %b want %b", status(), want);
    end
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    want = {2'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t4_disable: got %b want %b", status(), want);
    end
    step(6);
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t4_no_missed_later: got %b want %b", status(), want);
    end
  endtask

  task automatic test_ack_timeout_same();
    do_reset();
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = '0;
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t5_idle_ack: got %b want %b", status(), want);
    end
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    step(17);
    want = {2'd0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t5_ringing: got %b want %b", status(), want);
    end
    ack_pulse = 1'b1;
    step(1);
    ack_pulse = 1'b0;
    want = {2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t5_ack_beats_timeout: got %b want %b", status(), want);
    end
    select_pulse = 1'b1;
    step(4);
    vectors++;
    if (sel_slot !== 2'd0) begin
      miscompares++;
      $display("FAIL t5_sel_wrap: got %0d want 0", sel_slot);
    end
    step(1);
    select_pulse = 1'b0;
    vectors++;
    if (sel_slot !== 2'd1) begin
      miscompares++;
      $display("FAIL t5_sel_after5: got %0d want 1", sel_slot);
    end
  endtask

  task automatic test_reset_mid_ring();
    do_reset();
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
    load_pulse  = 1'b1;
    interval_in = 16'd7;
    step(1);
    load_pulse = 1'b0;
    step(10);
    want = {2'd1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t6_ringing: got %b want %b", status(), want);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    want = '0;
    vectors++;
    if (status() !== want || alarm_slot !== 2'd0) begin
      miscompares++;
      $display("FAIL t6_reset: got %b slot %0d want %b slot 0", status(), alarm_slot, want);
    end
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
    enable_pulse = 1'b1;
    step(1);
    enable_pulse = 1'b0;
    step(9);
    want = {2'd1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t6_before_expiry: got %b want %b", status(), want);
    end
    step(1);
    want = {2'd1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0};
    vectors++;
    if (status() !== want) begin
      miscompares++;
      $display("FAIL t6_interval_restored: got %b want %b", status(), want);
    end
  endtask

  initial begin
    test_reset();
    test_expire_ack();
    test_timeout();
    test_arbitration();
    test_disable_ringing();
    test_ack_timeout_same();
    test_reset_mid_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
